// File: rtl/if_id_queue_pkg.sv
// Shared widths and entry layout for the fetch-to-decode instruction queue.
package if_id_queue_pkg;

  localparam int unsigned WORD      = 64;
  localparam int unsigned INSTR_LEN = 32;
  localparam int unsigned IFQ_DEPTH = 4;
  localparam int unsigned ENTRY_W   = 2 * WORD + INSTR_LEN;

  typedef struct packed {
    logic [WORD-1:0]      pc;
    logic [WORD-1:0]      incremented_pc;
    logic [INSTR_LEN-1:0] instruction;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Entry register array: one write port, one asynchronous read port, no reset.
module ifq_storage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned W     = 160
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with valid/ready handshakes and one-cycle flush.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD-1:0]      in_pc,
  input  logic [WORD-1:0]      in_incremented_pc,
  input  logic [INSTR_LEN-1:0] in_instruction,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      out_pc,
  output logic [WORD-1:0]      out_incremented_pc,
  output logic [INSTR_LEN-1:0] out_instruction,
  output logic [AW:0]          count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          push, pop;
  ifq_entry_t    wr_entry, rd_entry;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // DEPTH is a power of two, so the AW-bit pointer increment wraps on its own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_entry = '{pc: in_pc, incremented_pc: in_incremented_pc, instruction: in_instruction};

  ifq_storage #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .W    (ENTRY_W)
  ) u_storage (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_entry),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_entry)
  );

  assign out_pc             = out_valid ? rd_entry.pc             : '0;
  assign out_incremented_pc = out_valid ? rd_entry.incremented_pc : '0;
  assign out_instruction    = out_valid ? rd_entry.instruction    : '0;
  assign count              = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid, in_ready, flush, out_valid, out_ready;
  logic [WORD-1:0]      in_pc, in_incremented_pc, out_pc, out_incremented_pc;
  logic [INSTR_LEN-1:0] in_instruction, out_instruction;
  logic [2:0]           count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] inc;
    logic [31:0] ins;
  } ref_entry_t;

  ref_entry_t model_q[$];

  if_id_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_pc             (in_pc),
    .in_incremented_pc (in_incremented_pc),
    .in_instruction    (in_instruction),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_incremented_pc(out_incremented_pc),
    .out_instruction   (out_instruction),
    .count             (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int unsigned n;
    n = model_q.size();
    check_eq({tag, ".count"}, 64'(count), 64'(n));
    check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(n != DEPTH));
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
    if (n != 0) begin
      check_eq({tag, ".pc"}, out_pc, model_q[0].pc);
      check_eq({tag, ".inc"}, out_incremented_pc, model_q[0].inc);
      check_eq({tag, ".ins"}, 64'(out_instruction), 64'(model_q[0].ins));
    end else begin
      check_eq({tag, ".pc0"}, out_pc, 64'd0);
      check_eq({tag, ".inc0"}, out_incremented_pc, 64'd0);
      check_eq({tag, ".ins0"}, 64'(out_instruction), 64'd0);
    end
  endtask

  // Applies one cycle of inputs, advances the model by the handshake rules, then checks.
  task automatic step(input string tag, input logic v, input logic [63:0] pc,
                      input logic [31:0] ins, input logic fl, input logic ordy);
    bit do_push, do_pop;
    ref_entry_t e;
    in_valid          = v;
    in_pc             = pc;
    in_incremented_pc = pc + 64'd4;
    in_instruction    = ins;
    flush             = fl;
    out_ready         = ordy;
    do_push = v && (model_q.size() < DEPTH) && !fl;
    do_pop  = (model_q.size() > 0) && ordy && !fl;
    e.pc = pc; e.inc = pc + 64'd4; e.ins = ins;
    @(posedge clk);
    #1;
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    check_state(tag);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b1; in_pc = 64'h100; in_incremented_pc = 64'h104;
    in_instruction = 32'hDEADBEEF; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check_state("reset");
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_state("post_reset");

    // Fill to full, then a rejected fifth push.
    for (int i = 0; i < 4; i++)
      step("fill", 1'b1, 64'(i * 4), $urandom, 1'b0, 1'b0);
    step("reject", 1'b1, 64'h10, 32'h11111111, 1'b0, 1'b0);

    // Drain from full with fetch pushing; pointers wrap.
    for (int i = 0; i < 8; i++)
      step("drain_wrap", 1'b1, 64'h10 + 64'(i * 4), $urandom, 1'b0, 1'b1);
    step("flush_a", 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // Single entry through an empty queue.
    step("single_in", 1'b1, 64'h40, 32'h8B020020, 1'b0, 1'b1);
    check_eq("single_ins", 64'(out_instruction), 64'h8B020020);
    step("single_out", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    step("empty_rdy", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

    // Flush beats a simultaneous push and pop.
    for (int i = 0; i < 3; i++)
      step("fill3", 1'b1, 64'h200 + 64'(i * 4), $urandom, 1'b0, 1'b0);
    step("flush_b", 1'b1, 64'h300, 32'h33333333, 1'b1, 1'b1);
    step("after_flush", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset between edges.
    for (int i = 0; i < 2; i++)
      step("fill2", 1'b1, 64'h400 + 64'(i * 4), $urandom, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_q.delete();
    check_state("async_reset");
    #1 reset = 1'b0;
    step("after_areset", 1'b1, 64'h500, 32'h55555555, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(3) != 0), {$urandom, $urandom}, $urandom,
           ($urandom_range(15) == 0), ($urandom_range(2) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
